// File: rtl/image_pkg.sv
// Frame buffer geometry shared by the frame writer and the RAM block,
// plus the writer FSM state type.
package image_pkg;

  localparam int IMG_W      = 320;
  localparam int IMG_H      = 240;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 17;
  localparam int MEM_DEPTH  = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HOLD
  } state_t;

endpackage

// File: rtl/frame_pos_counter.sv
// Raster position tracker: owns col/row/line_base and produces the linear
// RAM address by accumulation, so no multiplier is needed.
module frame_pos_counter #(
  parameter int IMG_W      = image_pkg::IMG_W,
  parameter int IMG_H      = image_pkg::IMG_H,
  parameter int ADDR_WIDTH = image_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  input  logic                  sof,
  input  logic                  eol,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_col,
  output logic                  last_row
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0]      col, col_eff;
  logic [ROW_W-1:0]      row, row_eff;
  logic [ADDR_WIDTH-1:0] line_base, base_eff;

  // An sof pixel sees the position as freshly reloaded, so its own eol
  // and last-column checks run against column 0 of row 0.
  always_comb begin
    col_eff  = sof ? '0 : col;
    row_eff  = sof ? '0 : row;
    base_eff = sof ? '0 : line_base;
    last_col = (col_eff == COL_W'(IMG_W - 1));
    last_row = (row_eff == ROW_W'(IMG_H - 1));
    addr     = base_eff + ADDR_WIDTH'(col_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      line_base <= '0;
    end else if (step) begin
      if (last_col || eol) begin
        col <= '0;
        if (last_row) begin
          row       <= '0;
          line_base <= '0;
        end else begin
          row       <= row_eff + ROW_W'(1);
          line_base <= base_eff + ADDR_WIDTH'(IMG_W);
        end
      end else begin
        col       <= col_eff + COL_W'(1);
        row       <= row_eff;
        line_base <= base_eff;
      end
    end
  end

endmodule

// File: rtl/image_frame_writer.sv
// Camera-side writer for the frame buffer RAM: registered write port, frame
// and line geometry checking. FRAME_STATS_EN adds frame/error counters.
module image_frame_writer
  import image_pkg::*;
#(
  parameter int IMG_W      = image_pkg::IMG_W,
  parameter int IMG_H      = image_pkg::IMG_H,
  parameter int DATA_WIDTH = image_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = image_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  pix_sof,
  input  logic                  pix_eol,
  input  logic                  continuous,
  input  logic                  arm,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           err_cnt
);

  state_t                state, state_next;
  logic                  err_flag;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last_col, last_row;
  logic                  accept, restart, done, line_err, err_next;

  frame_pos_counter #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (accept),
    .sof     (pix_sof),
    .eol     (pix_eol),
    .addr    (addr),
    .last_col(last_col),
    .last_row(last_row)
  );

  // A line is in error when eol and the last column disagree: an early eol
  // is a short line, a missing eol on the last column is a long line.
  always_comb begin
    accept     = pix_valid && (state == CAPTURE || (state == IDLE && pix_sof));
    restart    = pix_valid && pix_sof && (state == CAPTURE);
    done       = accept && (last_col || pix_eol) && last_row;
    line_err   = pix_eol ^ last_col;
    err_next   = (pix_sof ? 1'b0 : err_flag) | line_err;
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CAPTURE;
      CAPTURE: state_next = CAPTURE;
      HOLD:    if (arm) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (done) state_next = continuous ? IDLE : HOLD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      err_flag   <= 1'b0;
      busy       <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next == CAPTURE);
      mem_wr_en  <= accept;
      frame_done <= done;
      frame_err  <= restart || (done && err_next);
      if (accept) begin
        mem_addr <= addr;
        mem_data <= pix_data;
        err_flag <= err_next;
      end
    end
  end

`ifdef FRAME_STATS_EN
  // Frame count wraps; error count saturates so a flood of bad frames stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (frame_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = '0;
  assign err_cnt   = '0;
`endif

endmodule

// File: doc/image_frame_writer.md
Name: image_frame_writer

Overview:
- Upstream stage of the 320x240 8-bit frame buffer RAM.
- Accepts a raster pixel stream from the camera/pixel source: valid strobe, start-of-frame and end-of-line markers, no backpressure.
- Generates the linear write address, data and write enable for the RAM port, and checks frame and line geometry.
- Reports frame completion and errors to the control logic.

Parameters:
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per frame
- DATA_WIDTH, 8, pixel width
- ADDR_WIDTH, 17, RAM address width; must satisfy 2^ADDR_WIDTH >= IMG_W*IMG_H

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  pixel present this cycle
- pix_data  in  DATA_WIDTH  pixel value
- pix_sof  in  1  qualifies first pixel of a frame (valid only with pix_valid)
- pix_eol  in  1  qualifies last pixel of a line (valid only with pix_valid)
- continuous  in  1  1 = re-arm automatically after each frame; 0 = single-shot
- arm  in  1  one-cycle pulse; releases HOLD
- mem_wr_en  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_data  out  DATA_WIDTH  RAM write data
- busy  out  1  high in CAPTURE
- frame_done  out  1  one-cycle pulse when a frame completes
- frame_err  out  1  one-cycle pulse, coincident with frame_done or an sof restart, if the frame had a geometry error
- frame_cnt  out  16  completed-frame count (optional feature)
- err_cnt  out  16  errored-frame count (optional feature)

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters col, row, line_base and err_flag cleared.
- Reset mid-frame aborts immediately. No frame_done is produced; RAM contents are left as written.
- Accepted pixel: pix_valid=1 in IDLE with pix_sof=1, or any pix_valid=1 in CAPTURE.
- Write port outputs are registered. An accepted pixel produces mem_wr_en=1, mem_addr=line_base+col, mem_data=pix_data on the next cycle. Latency is 1 cycle and throughput is one pixel per clock.
- Addressing: line_base advances by IMG_W per line. No multiplier. The address never exceeds IMG_W*IMG_H-1.
- IDLE: pixels without sof are dropped. An sof pixel is written at address 0; then col=1, row=0, err_flag=0, go to CAPTURE.
- CAPTURE, normal pixel: written at line_base+col; col increments.
- CAPTURE, pix_eol:
  - If col != IMG_W-1 (short line), set err_flag.
  - Then col=0, row++, line_base+=IMG_W.
- CAPTURE, col == IMG_W-1 without eol (long line): the pixel is written, err_flag is set, and the line is treated as if eol were present.
- Last line: end of line on row IMG_H-1 completes the frame.
  - frame_done=1 on the cycle after that last pixel; frame_err=err_flag in the same cycle.
  - Next state is IDLE if continuous=1, else HOLD.
- CAPTURE, pix_sof: restart.
  - frame_err pulses on the next cycle (short frame); frame_done is not asserted.
  - Counters reload as in IDLE, and the sof pixel is written at address 0.
- sof and eol on the same pixel: sof processing happens first, then eol. This is a short-line error unless IMG_W=1.
- HOLD: all pixels dropped, no writes. arm=1 → IDLE. An sof arriving in the same cycle as arm is dropped.
- arm outside HOLD is ignored. continuous is sampled only at frame completion.
- busy=1 exactly while in CAPTURE.

Optional Feature:
- Macro: FRAME_STATS_EN.
- Defined:
  - frame_cnt increments on each frame_done and wraps at 2^16.
  - err_cnt increments on each frame_err and saturates at 0xFFFF.
  - Both clear on reset.
- Undefined: both ports remain present, tied to 0, with no counter flops.

Decomposition:
- Package image_pkg holds:
  - IMG_W, IMG_H, DATA_WIDTH, ADDR_WIDTH, MEM_DEPTH (=IMG_W*IMG_H)
  - the FSM state typedef {IDLE, CAPTURE, HOLD}
- The RAM block consumes the same constants.
- One sub-module is natural: frame_pos_counter. It owns col, row and line_base, produces the address, and flags last_col and last_row.
- The FSM and error logic stay in the top module.

Test Plan:
- Reset, continuous=1, then a clean 320x240 frame with one pixel per clock, data=addr[7:0] → 76800 writes with mem_addr 0..76799 in order, each 1 cycle after input; frame_done=1 and frame_err=0 at cycle 76801; frame_cnt=1.
- Line 5 eol sent at col 300 → row 6 starts at address 1920; frame_done with frame_err=1; err_cnt=1.
- sof injected at pixel 1000 of a frame → frame_err pulse without frame_done; next write at address 0.
- continuous=0: a frame completes → HOLD; a following sof frame produces no writes; arm pulse, then sof → capture resumes at address 0.
- Reset asserted mid-line at address 500 → mem_wr_en, busy, frame_done and frame_err drop to 0 immediately (async); after release, non-sof pixels are dropped in IDLE.
- Pixels with gaps (pix_valid toggling 1-0-1) → addresses stay contiguous and no spurious writes occur on idle cycles.
